// File: rtl/mult_dse_pkg.sv
// Shared definitions for the multiplier sweep checker.
//   state_e   : sweep controller states
//   tag_t     : per-vector tag carried alongside the candidate's latency
//   vec_count : number of operand pairs for a given operand width
// Tag fields are sized for operands up to TAG_W bits; narrower operands
// are zero-extended into them.
package mult_dse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int TAG_W  = 8;
  localparam int GOLD_W = 2 * TAG_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  a;
    logic [TAG_W-1:0]  b;
    logic [GOLD_W-1:0] golden;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, a: {TAG_W{1'b0}},
                                b: {TAG_W{1'b0}}, golden: {GOLD_W{1'b0}}};

  // Number of (A,B) pairs swept for a given operand width: 2^(2*width).
  function automatic int vec_count(input int width);
    return 32'sd1 << (2 * width);
  endfunction

endpackage

// File: rtl/mult_sweep_checker_if.sv
// Bus between the sweep checker, the candidate multiplier and the
// exploration loop that reads the verdict.
//   start            : one-cycle sweep request
//   mult_a / mult_b  : operands to the candidate
//   mult_p           : product from the candidate
//   busy/done/pass   : sweep status and verdict
//   err_count, err_valid, first_err_a/b/p : error report
// master = checker side, slave = environment side.
interface mult_sweep_checker_if #(
  parameter int WIDTH     = 2,
  parameter int ERR_CNT_W = 2 * WIDTH + 1
);
  logic                   start;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [2*WIDTH-1:0]     mult_p;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [ERR_CNT_W-1:0]   err_count;
  logic                   err_valid;
  logic [WIDTH-1:0]       first_err_a;
  logic [WIDTH-1:0]       first_err_b;
  logic [2*WIDTH-1:0]     first_err_p;

  modport master (
    input  start, mult_p,
    output mult_a, mult_b, busy, done, pass, err_count, err_valid,
           first_err_a, first_err_b, first_err_p
  );

  modport slave (
    output start, mult_p,
    input  mult_a, mult_b, busy, done, pass, err_count, err_valid,
           first_err_a, first_err_b, first_err_p
  );
endinterface

// File: rtl/sweep_tag_pipe.sv
// Delay line that keeps each vector's tag in step with the candidate's
// pipeline so the tag leaves exactly when the matching product arrives.
//   clk, rst      : clock, asynchronous active-high clear
//   tag_i         : tag entering this cycle
//   tag_o         : oldest tag (DEPTH cycles after entry)
//   any_valid_o   : at least one valid tag is still in flight
module sweep_tag_pipe
  import mult_dse_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  tag_t stage_q [DEPTH];

  // Shift register: stage 0 takes the new tag, the last stage is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  // OR of all valid bits; the controller drains until this falls.
  always_comb begin
    any_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_o = any_valid_o | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/mult_sweep_checker.sv
// Exhaustive sweep driver/checker for a candidate combinational or
// pipelined multiplier. Presents every (A,B) pair once (A outer, B inner),
// compares each returned product with the exact A*B and reports an error
// count, the first failing vector and a pass/fail verdict.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mult_sweep_checker_if master (start in, operands out,
//              product in, status and error report out)
// Parameters: WIDTH operand bits (at most TAG_W), DUT_LAT register stages
// inside the candidate, ERR_CNT_W error counter width (saturating).
module mult_sweep_checker
  import mult_dse_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int DUT_LAT   = 0,
  parameter int ERR_CNT_W = 2 * WIDTH + 1
) (
  input  logic                clk,
  input  logic                rst,
  mult_sweep_checker_if.master bus
);

  localparam int                 VW       = 2 * WIDTH;
  localparam int                 NVEC     = vec_count(WIDTH);
  localparam logic [VW-1:0]      V_LAST   = VW'(NVEC - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ZERO = {ERR_CNT_W{1'b0}};

  state_e               state_q, state_d;
  logic [VW-1:0]        v_q, v_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_valid_q, err_valid_d;
  logic [WIDTH-1:0]     fe_a_q, fe_a_d;
  logic [WIDTH-1:0]     fe_b_q, fe_b_d;
  logic [VW-1:0]        fe_p_q, fe_p_d;

  logic [VW-1:0]        v_inc_s;
  logic                 push_valid_s;
  tag_t                 tag_in_s;
  tag_t                 tag_out_s;
  logic                 any_valid_s;
  logic                 pad_bad_s;
  logic                 mismatch_s;

  assign v_inc_s = v_q + VW'(1);

  sweep_tag_pipe #(
    .DEPTH (DUT_LAT + 1)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag_in_s),
    .tag_o       (tag_out_s),
    .any_valid_o (any_valid_s)
  );

  // Tag for the vector launched this edge; golden kept at full width.
  always_comb begin
    tag_in_s        = TAG_IDLE;
    tag_in_s.valid  = push_valid_s;
    tag_in_s.a      = TAG_W'(a_d);
    tag_in_s.b      = TAG_W'(b_d);
    tag_in_s.golden = GOLD_W'(a_d) * GOLD_W'(b_d);
  end

  // Padding above WIDTH is always zero; a set bit means a corrupted tag,
  // which is reported as a miscompare rather than silently ignored.
  assign pad_bad_s  = (|(tag_out_s.a >> WIDTH)) | (|(tag_out_s.b >> WIDTH));
  assign mismatch_s = tag_out_s.valid &
                      ((tag_out_s.golden != GOLD_W'(bus.mult_p)) | pad_bad_s);

  // Controller next state, operand sequencing and error bookkeeping.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    err_valid_d  = err_valid_q;
    fe_a_d       = fe_a_q;
    fe_b_d       = fe_b_q;
    fe_p_d       = fe_p_q;
    push_valid_s = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Vector 0 launches on the start edge itself.
          state_d      = SWEEP;
          v_d          = {VW{1'b0}};
          a_d          = {WIDTH{1'b0}};
          b_d          = {WIDTH{1'b0}};
          push_valid_s = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_cnt_d    = ERR_ZERO;
          err_valid_d  = 1'b0;
          fe_a_d       = {WIDTH{1'b0}};
          fe_b_d       = {WIDTH{1'b0}};
          fe_p_d       = {VW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      SWEEP: begin
        if (v_q == V_LAST) begin
          // Operands hold the last vector; only invalid tags follow.
          state_d = DRAIN;
        end else begin
          v_d          = v_inc_s;
          a_d          = v_inc_s[VW-1:WIDTH];
          b_d          = v_inc_s[WIDTH-1:0];
          push_valid_s = 1'b1;
        end
      end
      DRAIN: begin
        if (!any_valid_s) begin
          // Last compare already landed in err_cnt_q.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == ERR_ZERO);
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    if (mismatch_s) begin
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        fe_a_d      = tag_out_s.a[WIDTH-1:0];
        fe_b_d      = tag_out_s.b[WIDTH-1:0];
        fe_p_d      = bus.mult_p;
      end else begin
        err_valid_d = err_valid_q;
      end
    end else begin
      err_valid_d = err_valid_d;
    end
  end

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= {VW{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= ERR_ZERO;
      err_valid_q <= 1'b0;
      fe_a_q      <= {WIDTH{1'b0}};
      fe_b_q      <= {WIDTH{1'b0}};
      fe_p_q      <= {VW{1'b0}};
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      fe_a_q      <= fe_a_d;
      fe_b_q      <= fe_b_d;
      fe_p_q      <= fe_p_d;
    end
  end

  assign bus.mult_a      = a_q;
  assign bus.mult_b      = b_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.err_count   = err_cnt_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.first_err_a = fe_a_q;
  assign bus.first_err_b = fe_b_q;
  assign bus.first_err_p = fe_p_q;

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Directed bench for mult_sweep_checker. Three checker instances:
//   a: defaults, candidate selectable (correct / P[0] stuck at 0 / P=0)
//   b: ERR_CNT_W=3 with P tied to 0 (saturation)
//   c: DUT_LAT=1, candidate registered or purely combinational
module tb_mult_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   mode_a;
  logic regmode_c;
  logic [3:0] p_c_q;

  always #5 clk = ~clk;

  mult_sweep_checker_if #(.WIDTH(2))                 if_a ();
  mult_sweep_checker_if #(.WIDTH(2), .ERR_CNT_W(3))  if_b ();
  mult_sweep_checker_if #(.WIDTH(2))                 if_c ();

  mult_sweep_checker #(.WIDTH(2), .DUT_LAT(0)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mult_sweep_checker #(.WIDTH(2), .DUT_LAT(0), .ERR_CNT_W(3)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mult_sweep_checker #(.WIDTH(2), .DUT_LAT(1)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Candidate for instance a.
  always_comb begin
    case (mode_a)
      1:       if_a.mult_p = (4'(if_a.mult_a) * 4'(if_a.mult_b)) & 4'b1110;
      2:       if_a.mult_p = 4'd0;
      default: if_a.mult_p = 4'(if_a.mult_a) * 4'(if_a.mult_b);
    endcase
  end

  assign if_b.mult_p = 4'd0;

  // One-stage registered candidate for instance c.
  always_ff @(posedge clk) begin
    p_c_q <= 4'(if_c.mult_a) * 4'(if_c.mult_b);
  end

  assign if_c.mult_p = regmode_c ? p_c_q : 4'(if_c.mult_a) * 4'(if_c.mult_b);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic val);
    case (sel)
      0:       if_a.start = val;
      1:       if_b.start = val;
      default: if_c.start = val;
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return if_a.done;
      1:       return if_b.done;
      default: return if_c.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  // Pulse start, then count edges until done (bounded). poke_at re-pulses
  // start at that cycle of the sweep; d0 is done right after the start edge.
  task automatic run_sweep(input int sel, input int poke_at,
                           output int cyc, output int busy_cyc, output logic d0);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    d0       = get_done(sel);
    cyc      = 0;
    busy_cyc = 0;
    while (!get_done(sel) && cyc < 100) begin
      if (get_busy(sel)) busy_cyc++;
      @(posedge clk);
      #1;
      cyc++;
      set_start(sel, (cyc == poke_at));
    end
    set_start(sel, 1'b0);
  endtask

  initial begin
    int   cyc;
    int   bcyc;
    logic d0;

    rst       = 1'b1;
    mode_a    = 0;
    regmode_c = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    #12;
    check_val("rst_busy", 32'(if_a.busy), 0);
    check_val("rst_done", 32'(if_a.done), 0);
    check_val("rst_errcnt", 32'(if_a.err_count), 0);
    check_val("rst_mult_a", 32'(if_a.mult_a), 0);
    @(negedge clk);
    rst = 1'b0;

    // Correct candidate.
    run_sweep(0, -1, cyc, bcyc, d0);
    check_val("ok_latency", cyc, 17);
    check_val("ok_busy_cycles", bcyc, 17);
    check_val("ok_pass", 32'(if_a.pass), 1);
    check_val("ok_errcnt", 32'(if_a.err_count), 0);
    check_val("ok_errvalid", 32'(if_a.err_valid), 0);

    // P[0] stuck at 0: odd*odd vectors fail.
    mode_a = 1;
    run_sweep(0, -1, cyc, bcyc, d0);
    check_val("stuck_errcnt", 32'(if_a.err_count), 4);
    check_val("stuck_fe_a", 32'(if_a.first_err_a), 1);
    check_val("stuck_fe_b", 32'(if_a.first_err_b), 1);
    check_val("stuck_fe_p", 32'(if_a.first_err_p), 0);
    check_val("stuck_pass", 32'(if_a.pass), 0);
    check_val("stuck_errvalid", 32'(if_a.err_valid), 1);

    // P=0 with a wide counter: all nine nonzero products fail.
    mode_a = 2;
    run_sweep(0, -1, cyc, bcyc, d0);
    check_val("zero_errcnt_wide", 32'(if_a.err_count), 9);

    // P=0 with a 3-bit counter: saturates at 7.
    run_sweep(1, -1, cyc, bcyc, d0);
    check_val("sat_errcnt", 32'(if_b.err_count), 7);
    check_val("sat_fe_a", 32'(if_b.first_err_a), 1);
    check_val("sat_fe_b", 32'(if_b.first_err_b), 1);
    check_val("sat_fe_p", 32'(if_b.first_err_p), 0);
    check_val("sat_pass", 32'(if_b.pass), 0);

    // DUT_LAT=1, registered candidate.
    regmode_c = 1'b1;
    run_sweep(2, -1, cyc, bcyc, d0);
    check_val("lat1_latency", cyc, 18);
    check_val("lat1_pass", 32'(if_c.pass), 1);

    // DUT_LAT=1, unregistered candidate: each tag sees the next vector's
    // product; vectors 4..14 differ from their successor.
    regmode_c = 1'b0;
    run_sweep(2, -1, cyc, bcyc, d0);
    check_val("lat1_comb_pass", 32'(if_c.pass), 0);
    check_val("lat1_comb_errcnt", 32'(if_c.err_count), 11);
    check_val("lat1_comb_fe_a", 32'(if_c.first_err_a), 1);
    check_val("lat1_comb_fe_b", 32'(if_c.first_err_b), 0);
    check_val("lat1_comb_fe_p", 32'(if_c.first_err_p), 1);

    // Reset at v=6 with a faulty candidate so error state is nonzero.
    mode_a = 1;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("mid_mult_a", 32'(if_a.mult_a), 1);
    check_val("mid_mult_b", 32'(if_a.mult_b), 2);
    check_val("mid_errcnt", 32'(if_a.err_count), 1);
    check_val("mid_busy", 32'(if_a.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_busy", 32'(if_a.busy), 0);
    check_val("arst_done", 32'(if_a.done), 0);
    check_val("arst_pass", 32'(if_a.pass), 0);
    check_val("arst_errcnt", 32'(if_a.err_count), 0);
    check_val("arst_errvalid", 32'(if_a.err_valid), 0);
    check_val("arst_fe_a", 32'(if_a.first_err_a), 0);
    check_val("arst_fe_b", 32'(if_a.first_err_b), 0);
    check_val("arst_fe_p", 32'(if_a.first_err_p), 0);
    check_val("arst_mult_a", 32'(if_a.mult_a), 0);
    check_val("arst_mult_b", 32'(if_a.mult_b), 0);
    @(negedge clk);
    rst    = 1'b0;
    mode_a = 0;
    run_sweep(0, -1, cyc, bcyc, d0);
    check_val("post_rst_latency", cyc, 17);
    check_val("post_rst_pass", 32'(if_a.pass), 1);

    // start during a sweep is ignored.
    run_sweep(0, 5, cyc, bcyc, d0);
    check_val("busy_start_latency", cyc, 17);
    check_val("busy_start_pass", 32'(if_a.pass), 1);

    // start from DONE: done drops right away and a full sweep follows.
    run_sweep(0, -1, cyc, bcyc, d0);
    check_val("restart_done_drop", 32'(d0), 0);
    check_val("restart_latency", cyc, 17);
    check_val("restart_pass", 32'(if_a.pass), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
